// File: rtl/button_debounce_irq_pkg.sv
// Shared definitions for the button debounce / interrupt peripheral:
// bus widths, register offsets and the register-select decode.
package button_debounce_irq_pkg;

  localparam int MAX_CHANNELS = 32;
  localparam int WB_ADR_W     = 5;
  localparam int WB_DAT_W     = 32;

  // Byte offsets of the implemented registers (word aligned)
  localparam logic [WB_ADR_W-1:0] ADDR_LEVEL   = 5'h00;
  localparam logic [WB_ADR_W-1:0] ADDR_ENABLE  = 5'h04;
  localparam logic [WB_ADR_W-1:0] ADDR_PENDING = 5'h08;
  localparam logic [WB_ADR_W-1:0] ADDR_RISE    = 5'h0C;
  localparam logic [WB_ADR_W-1:0] ADDR_FALL    = 5'h10;

  typedef enum logic [2:0] {
    SEL_LEVEL,
    SEL_ENABLE,
    SEL_PENDING,
    SEL_RISE,
    SEL_FALL,
    SEL_NONE
  } reg_sel_e;

  // Map a word index (byte address bits [4:2]) onto a register select.
  function automatic reg_sel_e decode_reg(input logic [WB_ADR_W-3:0] word_idx);
    reg_sel_e sel;
    case ({word_idx, 2'b00})
      ADDR_LEVEL:   sel = SEL_LEVEL;
      ADDR_ENABLE:  sel = SEL_ENABLE;
      ADDR_PENDING: sel = SEL_PENDING;
      ADDR_RISE:    sel = SEL_RISE;
      ADDR_FALL:    sel = SEL_FALL;
      default:      sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/button_debounce_irq_if.sv
// Wishbone slave bundle for the button peripheral. Signal names keep the
// slave-side _i/_o suffixes so they read the same as the SoC bus wiring.
interface button_debounce_irq_if;
  import button_debounce_irq_pkg::*;

  logic [WB_ADR_W-1:0] wb_adr_i;
  logic [WB_DAT_W-1:0] wb_dat_i;
  logic [WB_DAT_W-1:0] wb_dat_o;
  logic [3:0]          wb_sel_i;
  logic                wb_we_i;
  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic                wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );

endinterface

// File: rtl/button_debounce_irq_debounce_channel.sv
// One input channel: two-flop synchroniser, hold-time debouncer and
// single-cycle rise/fall pulses derived from the debounced level.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [1:0]           sync_q;       // [0] may go metastable, [1] is safe to use
  logic                 stable_q;
  logic                 stable_d;
  logic                 stable_dly_q; // stable one cycle late, for edge pulses
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Debounce decision: count cycles the synchronised input disagrees with stable
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers: synchroniser, counter, stable level and its delayed copy
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // the synchroniser only behaves as a two-stage chain because of this.
    if (reset) begin
      sync_q       <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync_q       <= {sync_q[0], in_i};
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = stable_q & ~stable_dly_q;
  assign fall_o  = ~stable_q & stable_dly_q;

endmodule

// File: rtl/button_debounce_irq.sv
// Debounced button inputs with per-channel edge selection, W1C pending bits
// and one level interrupt, accessed as a Wishbone slave.
module button_debounce_irq
  import button_debounce_irq_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_i,
  button_debounce_irq_if.slave wb,
  output logic                irq_o,
  output logic [CHANNELS-1:0] level_o
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);

  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;

  logic [CHANNELS-1:0] enable_q,   enable_d;
  logic [CHANNELS-1:0] pending_q,  pending_d;
  logic [CHANNELS-1:0] rise_sel_q, rise_sel_d;
  logic [CHANNELS-1:0] fall_sel_q, fall_sel_d;
  logic                ack_q,      ack_d;
  logic [WB_DAT_W-1:0] dat_q,      dat_d;
  logic                irq_q,      irq_d;

  reg_sel_e            sel;
  logic                access;
  logic                write;
  logic [CHANNELS-1:0] wdata;
  logic [WB_DAT_W-1:0] rdata;
  logic                unused_ok;

  // Byte lanes, sub-word address bits and data bits above CHANNELS carry no meaning
  assign unused_ok = ^{wb.wb_sel_i, wb.wb_adr_i[1:0], wb.wb_dat_i};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .in_i    (btn_i[i]),
      .level_o (level_o[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i])
    );
  end

  // Bus decode: a request is taken only when no ack is outstanding
  always_comb begin
    sel    = decode_reg(wb.wb_adr_i[WB_ADR_W-1:2]);
    access = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    write  = access & wb.wb_we_i;
    wdata  = wb.wb_dat_i[CHANNELS-1:0];
  end

  // Register updates; a new edge event wins over a same-cycle W1C
  always_comb begin
    enable_d   = enable_q;
    rise_sel_d = rise_sel_q;
    fall_sel_d = fall_sel_q;
    pending_d  = pending_q;
    if (write) begin
      case (sel)
        SEL_ENABLE:  enable_d   = wdata;
        SEL_PENDING: pending_d  = pending_q & ~wdata;
        SEL_RISE:    rise_sel_d = wdata;
        SEL_FALL:    fall_sel_d = wdata;
        default:     ;
      endcase
    end
    pending_d = pending_d | (rise & rise_sel_q) | (fall & fall_sel_q);
  end

  // Read mux, ack generation and interrupt
  always_comb begin
    rdata = '0;
    case (sel)
      SEL_LEVEL:   rdata = WB_DAT_W'(level_o);
      SEL_ENABLE:  rdata = WB_DAT_W'(enable_q);
      SEL_PENDING: rdata = WB_DAT_W'(pending_q);
      SEL_RISE:    rdata = WB_DAT_W'(rise_sel_q);
      SEL_FALL:    rdata = WB_DAT_W'(fall_sel_q);
      default:     rdata = '0;
    endcase
    dat_d = (access && !wb.wb_we_i) ? rdata : '0;
    ack_d = access;
    irq_d = |(pending_q & enable_q);
  end

  // Control/status registers and bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q   <= '0;
      pending_q  <= '0;
      rise_sel_q <= '0;
      fall_sel_q <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      rise_sel_q <= rise_sel_d;
      fall_sel_q <= fall_sel_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      irq_q      <= irq_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq_o       = irq_q;

endmodule

// File: doc/button_debounce_irq.md
Name: button_debounce_irq

Overview:
Parametrised successor to the fixed 4-button input path of the SoC. Synchronises and debounces CHANNELS asynchronous button/switch inputs and detects rising and/or falling edges per channel. Latches edge events in write-1-to-clear pending bits and drives one level interrupt to the CPU interrupt controller. Sits on the SoC Wishbone bus as a slave, next to the UART and LED/switch peripherals.

Parameters:
CHANNELS, 4, number of input channels (1..32)
DEBOUNCE_CYCLES, 1000, cycles an input must hold a new value before it is accepted (>=2)
CNT_WIDTH, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived; never overridden)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_i  in  CHANNELS  raw asynchronous inputs, active-high
wb_adr_i  in  5  byte address; bits [4:2] decoded
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data
wb_sel_i  in  4  byte select; ignored, all accesses are full-word
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_ack_o  out  1  single-cycle acknowledge
irq_o  out  1  interrupt, level, active-high
level_o  out  CHANNELS  debounced levels, for direct LED or test use

Behaviour:
- Reset: all of the following clear to 0: sync flops, stable levels, counters, ENABLE, PENDING, RISE, FALL, wb_ack_o, wb_dat_o, irq_o, level_o.
- Synchroniser: 2-flop chain per channel. sync = second flop.
- Debounce, per channel:
  - If sync == stable, the counter clears.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and sync still differs, on the next edge stable <= sync and the counter clears.
  - Latency from a btn_i change to a level_o change = 2 + DEBOUNCE_CYCLES cycles.
  - A pulse shorter than DEBOUNCE_CYCLES cycles (after sync) never changes stable.
- Edge detection:
  - rise = stable & ~stable_d; fall = ~stable & stable_d.
  - Each is a one-cycle pulse in the cycle after stable changes.
- Pending:
  - PENDING[i] sets on (rise[i] & RISE[i]) | (fall[i] & FALL[i]).
  - PENDING sets independently of ENABLE.
- Interrupt: irq_o = |(PENDING & ENABLE), registered, so one cycle after PENDING/ENABLE update.
- Register map (unimplemented upper bits read 0, writes to them are ignored):
  - 0x00 LEVEL, RO: stable levels.
  - 0x04 ENABLE, RW.
  - 0x08 PENDING, W1C.
  - 0x0C RISE, RW: rising-edge select.
  - 0x10 FALL, RW: falling-edge select.
  - 0x14..0x1C: read 0, writes ignored.
- Simultaneous W1C and a new set event on the same bit: set wins, bit stays 1.
- Wishbone handshake:
  - wb_ack_o <= cyc & stb & ~wb_ack_o, i.e. ack one cycle after the request, one-cycle pulse.
  - A held strobe gets an ack every other cycle.
  - Write side-effects occur in the ack cycle; wb_dat_o is valid in the ack cycle.
- Reset mid-debounce: the counter and stable clear, so a held button re-qualifies after 2 + DEBOUNCE_CYCLES cycles and then produces a rising edge.
- Reset mid-bus-cycle: ack suppressed in the reset cycle; the master must retry.

Decomposition:
- Shared package/include `button_irq_defs`:
  - register offsets: ADDR_LEVEL, ADDR_ENABLE, ADDR_PENDING, ADDR_RISE, ADDR_FALL;
  - MAX_CHANNELS = 32.
- Sub-module `debounce_channel` (params DEBOUNCE_CYCLES, CNT_WIDTH; ports clk, reset, in, level, rise, fall).
  - Generate-instantiated CHANNELS times.
  - Top level holds registers, bus decode and irq.

Test Plan (bench uses CHANNELS=4, DEBOUNCE_CYCLES=16):
1. Reset, then read 0x00..0x10 -> all 0x00000000; irq_o=0; one ack per access.
2. RISE=0x1, ENABLE=0x1; btn_i[0]=1 held -> level_o[0]=1 at 18 cycles after the change; PENDING=0x1; irq_o=1 one cycle later. Write 0x1 to 0x08 -> PENDING=0, irq_o=0.
3. btn_i[1] 10-cycle glitch -> level_o, PENDING and irq_o unchanged for 40 cycles.
4. FALL=0x4, ENABLE=0; press then release btn_i[2] -> PENDING=0x4, irq_o=0. Write ENABLE=0x4 -> irq_o=1 next cycle.
5. W1C on PENDING[3] in the same cycle a rising edge sets it (RISE=0x8) -> PENDING[3] remains 1.
6. Assert reset with btn_i[0]=1 at counter=8 -> level_o=0; after release, level_o[0]=1 exactly 18 cycles later; PENDING[0] sets only if RISE[0] was rewritten.
